// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared state encoding and register-window offsets for dmem_responder.
// Revision : 1.0
// ============================================================================
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } dmem_state_t;

    // Byte offsets inside the 16-byte register window.
    localparam logic [3:0] CYCLE_OFS = 4'd0;
    localparam logic [3:0] STCNT_OFS = 4'd4;
    localparam logic [3:0] HALT_OFS  = 4'd8;
    localparam logic [3:0] SIG_OFS   = 4'd12;

endpackage
`default_nettype wire

// File: rtl/dmem_mmio_regs.sv
`default_nettype none
// ============================================================================
// Module   : dmem_mmio_regs
// Purpose  : CYCLE / STCNT / SIG registers and the register-window read mux.
// Revision : 1.0
// ============================================================================
module dmem_mmio_regs
    import dmem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        ram_store,
    input  logic        sig_we,
    input  logic [31:0] sig_wdata,
    input  logic [1:0]  rd_sel,
    input  logic        halted,
    output logic [31:0] rd_data,
    output logic [31:0] signature
);

    logic [31:0] r_cycle;
    logic [31:0] r_stcnt;
    logic [31:0] r_sig;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle <= '0;
            r_stcnt <= '0;
            r_sig   <= '0;
        end else begin
            if (run) begin
                r_cycle <= r_cycle + 32'd1;
            end
            if (ram_store) begin
                r_stcnt <= r_stcnt + 32'd1;
            end
            if (sig_we) begin
                r_sig <= sig_wdata;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_sel)
            CYCLE_OFS[3:2]: rd_data = r_cycle;
            STCNT_OFS[3:2]: rd_data = r_stcnt;
            HALT_OFS[3:2]:  rd_data = {31'b0, halted};
            SIG_OFS[3:2]:   rd_data = r_sig;
            default:        rd_data = '0;
        endcase
    end

    assign signature = r_sig;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Data-side memory responder: word RAM, boot loader port, register
//            window and LOAD/RUN/HALT sequencing. Optional macro
//            DMEM_FAULT_HALT_EN makes an out-of-range access halt the program.
// Revision : 1.0
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH     = 64,
    parameter int          AW        = 6,
    parameter logic [31:0] MMIO_BASE = 32'h0000_0100
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   data_addr,
    input  logic [31:0]   data_out,
    output logic [31:0]   data_in,
    input  logic          mem_write,
    input  logic          mem_read,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data,
    input  logic          ld_done,
    output logic          cpu_rst,
    output logic          halted,
    output logic          fault,
    output logic [31:0]   signature
);

    localparam logic [31:0] c_ram_bytes = 32'(DEPTH * 4);

    dmem_state_t   r_state;
    logic          r_cpu_rst;
    logic          r_halted;
    logic          r_fault;
    logic [31:0]   r_mem [DEPTH];

    logic [AW-1:0] w_idx;
    logic [31:0]   w_mmio_ofs;
    logic          w_in_ram;
    logic          w_in_mmio;
    logic          w_run;
    logic          w_bad;
    logic          w_fault_halt;
    logic          w_store;
    logic          w_ram_store;
    logic          w_halt_store;
    logic          w_sig_we;
    logic [31:0]   w_reg_rd;

    assign w_idx      = data_addr[AW+1:2];
    assign w_mmio_ofs = data_addr - MMIO_BASE;
    assign w_in_ram   = (data_addr < c_ram_bytes);
    // Modular subtraction: addresses below the base wrap high and fail this test.
    assign w_in_mmio  = (w_mmio_ofs < 32'd16);
    assign w_run      = (r_state == ST_RUN);
    assign w_bad      = w_run && (mem_read || mem_write) && !w_in_ram && !w_in_mmio;

`ifdef DMEM_FAULT_HALT_EN
    assign w_fault_halt = w_bad;
`else
    assign w_fault_halt = 1'b0;
`endif

    assign w_store      = w_run && mem_write && !w_bad && !rst;
    assign w_ram_store  = w_store && w_in_ram;
    assign w_halt_store = w_store && w_in_mmio && (w_mmio_ofs[3:2] == HALT_OFS[3:2]);
    assign w_sig_we     = w_store && w_in_mmio && (w_mmio_ofs[3:2] == SIG_OFS[3:2]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_LOAD;
            r_cpu_rst <= 1'b1;
            r_halted  <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (ld_done) begin
                        r_state   <= ST_RUN;
                        r_cpu_rst <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (w_halt_store || w_fault_halt) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_HALT;
                end
            endcase
            if (w_bad) begin
                r_fault <= 1'b1;
            end
        end
    end

    // RAM is deliberately not reset so a cpu reset keeps the loaded image.
    always_ff @(posedge clk) begin
        if (!rst && (r_state == ST_LOAD) && ld_valid) begin
            r_mem[ld_addr] <= ld_data;
        end else if (w_ram_store) begin
            r_mem[w_idx] <= data_out;
        end
    end

    dmem_mmio_regs u_regs (
        .clk       (clk),
        .rst       (rst),
        .run       (w_run),
        .ram_store (w_ram_store),
        .sig_we    (w_sig_we),
        .sig_wdata (data_out),
        .rd_sel    (w_mmio_ofs[3:2]),
        .halted    (r_halted),
        .rd_data   (w_reg_rd),
        .signature (signature)
    );

    always_comb begin
        data_in = '0;
        if (mem_read && (r_state != ST_LOAD)) begin
            if (w_in_ram) begin
                data_in = r_mem[w_idx];
            end else if (w_in_mmio) begin
                data_in = w_reg_rd;
            end
        end
    end

    assign cpu_rst = r_cpu_rst;
    assign halted  = r_halted;
    assign fault   = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Directed boot/run/halt scenarios plus random traffic, checked
//            against an array-based behavioural model of the responder.
// Revision : 1.0
// ============================================================================
module tb_dmem_responder;

    localparam int          DEPTH     = 64;
    localparam int          AW        = 6;
    localparam logic [31:0] MMIO_BASE = 32'h0000_0100;
    localparam int          S_LOAD    = 0;
    localparam int          S_RUN     = 1;
    localparam int          S_HALT    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   data_addr = '0;
    logic [31:0]   data_out = '0;
    logic          mem_write = 1'b0;
    logic          mem_read = 1'b0;
    logic          ld_valid = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [31:0]   ld_data = '0;
    logic          ld_done = 1'b0;
    logic [31:0]   data_in;
    logic          cpu_rst;
    logic          halted;
    logic          fault;
    logic [31:0]   signature;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .AW(AW), .MMIO_BASE(MMIO_BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_addr (data_addr),
        .data_out  (data_out),
        .data_in   (data_in),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_done   (ld_done),
        .cpu_rst   (cpu_rst),
        .halted    (halted),
        .fault     (fault),
        .signature (signature)
    );

    int          checks = 0;
    int          failures = 0;
    int          m_state = S_LOAD;
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_cycle = '0;
    logic [31:0] m_stcnt = '0;
    logic [31:0] m_sig = '0;
    logic        m_fault = 1'b0;
    logic [31:0] vals [DEPTH];
    logic [31:0] rd_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic in_ram(input logic [31:0] a);
        return a < 32'(DEPTH * 4);
    endfunction

    function automatic logic in_mmio(input logic [31:0] a);
        return (a >= MMIO_BASE) && (a < MMIO_BASE + 32'd16);
    endfunction

    function automatic logic [31:0] model_read();
        if (m_state == S_LOAD || !mem_read) return '0;
        if (in_ram(data_addr)) return m_mem[int'(data_addr >> 2)];
        if (in_mmio(data_addr)) begin
            case (int'((data_addr - MMIO_BASE) >> 2))
                0:       return m_cycle;
                1:       return m_stcnt;
                2:       return {31'b0, m_state == S_HALT};
                default: return m_sig;
            endcase
        end
        return '0;
    endfunction

    task automatic model_update();
        logic bad;
        int   ofs;
        if (rst) begin
            m_state = S_LOAD;
            m_cycle = '0;
            m_stcnt = '0;
            m_sig   = '0;
            m_fault = 1'b0;
            return;
        end
        if (m_state == S_LOAD) begin
            if (ld_valid) m_mem[int'(ld_addr)] = ld_data;
            if (ld_done) m_state = S_RUN;
        end else if (m_state == S_RUN) begin
            m_cycle = m_cycle + 32'd1;
            bad = (mem_read || mem_write) && !in_ram(data_addr) && !in_mmio(data_addr);
            if (bad) begin
                m_fault = 1'b1;
`ifdef DMEM_FAULT_HALT_EN
                m_state = S_HALT;
`endif
            end else if (mem_write) begin
                if (in_ram(data_addr)) begin
                    m_mem[int'(data_addr >> 2)] = data_out;
                    m_stcnt = m_stcnt + 32'd1;
                end else begin
                    ofs = int'((data_addr - MMIO_BASE) >> 2);
                    if (ofs == 2) m_state = S_HALT;
                    else if (ofs == 3) m_sig = data_out;
                end
            end
        end
    endtask

    // One clock: check the combinational load mid-cycle, then the registered outputs after the edge.
    task automatic step();
        @(negedge clk);
        rd_seen = data_in;
        check("data_in", data_in, model_read());
        @(posedge clk);
        model_update();
        #1;
        check("cpu_rst", {31'b0, cpu_rst}, {31'b0, m_state == S_LOAD});
        check("halted", {31'b0, halted}, {31'b0, m_state == S_HALT});
        check("fault", {31'b0, fault}, {31'b0, m_fault});
        check("signature", signature, m_sig);
    endtask

    task automatic cpu(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        mem_read  = rd;
        mem_write = wr;
        data_addr = addr;
        data_out  = wdata;
        step();
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        int pick;
        pick = int'($urandom_range(0, 9));
        if (pick < 6) return {24'b0, 6'($urandom), 2'($urandom)};
        if (pick < 9) return MMIO_BASE + 32'($urandom_range(0, 15));
        return 32'h110 + 32'($urandom_range(0, 4000));
    endfunction

    initial begin
        // Reset state
        rst = 1'b1;
        step();
        mem_read  = 1'b1;
        data_addr = 32'h0;
        step();
        mem_read = 1'b0;
        check("rst_data_in", rd_seen, 32'h0);
        check("rst_cpu_rst", {31'b0, cpu_rst}, 32'h1);
        check("rst_signature", signature, 32'h0);
        rst = 1'b0;

        // Boot load: whole image, then the test words
        for (int i = 0; i < DEPTH; i++) begin
            vals[i] = (i == DEPTH - 1) ? 32'hA5A5_0063 : $urandom;
        end
        vals[0] = 32'd50;
        vals[1] = 32'd7;
        vals[2] = 32'd3;
        vals[3] = 32'd9;
        vals[5] = 32'h55;
        for (int i = 0; i < DEPTH; i++) begin
            ld_valid = 1'b1;
            ld_addr  = AW'(i);
            ld_data  = vals[i];
            step();
            check("cpu_rst_loading", {31'b0, cpu_rst}, 32'h1);
        end
        ld_valid = 1'b0;
        cpu(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
        check("load_state_rd", rd_seen, 32'h0);
        ld_valid = 1'b1;
        ld_addr  = AW'(5);
        ld_data  = 32'h55;
        ld_done  = 1'b1;
        step();
        ld_valid = 1'b0;
        ld_done  = 1'b0;
        check("cpu_rst_release", {31'b0, cpu_rst}, 32'h0);

        // RUN reads and same-cycle store/load
        cpu(1'b1, 1'b0, 32'h0, 32'h0);
        check("rd_0x0", rd_seen, 32'd50);
        cpu(1'b1, 1'b0, 32'h8, 32'h0);
        check("rd_0x8", rd_seen, 32'd3);
        cpu(1'b1, 1'b0, 32'h14, 32'h0);
        check("rd_ld_with_done", rd_seen, 32'h55);
        cpu(1'b1, 1'b0, 32'h10, 32'h0);
        check("load_store_ignored", rd_seen, vals[4]);
        cpu(1'b1, 1'b1, 32'h10, 32'h3E8);
        check("same_cycle_old", rd_seen, vals[4]);
        cpu(1'b1, 1'b0, 32'h10, 32'h0);
        check("store_new", rd_seen, 32'h3E8);
        cpu(1'b1, 1'b0, 32'h104, 32'h0);
        check("stcnt_1", rd_seen, 32'd1);
        cpu(1'b1, 1'b0, 32'hFC, 32'h0);
        check("rd_top_word", rd_seen, 32'hA5A5_0063);

        // Reset in the middle of RUN with CYCLE=20
        for (int n = 0; n < 40 && m_cycle < 32'd20; n++) step();
        check("cycle_reached_20", m_cycle, 32'd20);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrun_cpu_rst", {31'b0, cpu_rst}, 32'h1);
        ld_done = 1'b1;
        step();
        ld_done = 1'b0;
        cpu(1'b1, 1'b0, 32'h100, 32'h0);
        check("cycle_cleared", rd_seen, 32'h0);
        cpu(1'b1, 1'b0, 32'h104, 32'h0);
        check("stcnt_cleared", rd_seen, 32'h0);
        cpu(1'b1, 1'b0, 32'h10, 32'h0);
        check("ram_kept", rd_seen, 32'h3E8);

        // Signature, HALT and freezing
        cpu(1'b0, 1'b1, 32'h10C, 32'hCAFE);
        cpu(1'b0, 1'b1, 32'h108, 32'h1);
        check("sig_cafe", signature, 32'hCAFE);
        check("halted_set", {31'b0, halted}, 32'h1);
        cpu(1'b0, 1'b1, 32'h10, 32'h1234);
        cpu(1'b1, 1'b0, 32'h10, 32'h0);
        check("halt_store_dropped", rd_seen, 32'h3E8);
        cpu(1'b1, 1'b0, 32'h100, 32'h0);
        check("cycle_at_halt", rd_seen, 32'd5);
        repeat (5) step();
        cpu(1'b1, 1'b0, 32'h100, 32'h0);
        check("cycle_frozen", rd_seen, 32'd5);
        cpu(1'b1, 1'b0, 32'h108, 32'h0);
        check("halt_reg_rd", rd_seen, 32'h1);

        // Out-of-range access
        rst = 1'b1;
        step();
        rst = 1'b0;
        ld_done = 1'b1;
        step();
        ld_done = 1'b0;
        cpu(1'b1, 1'b0, 32'h200, 32'h0);
        check("oor_rd_zero", rd_seen, 32'h0);
        check("fault_set", {31'b0, fault}, 32'h1);
`ifdef DMEM_FAULT_HALT_EN
        check("fault_halts", {31'b0, halted}, 32'h1);
`else
        check("fault_no_halt", {31'b0, halted}, 32'h0);
        cpu(1'b0, 1'b1, 32'h4, 32'h77);
        cpu(1'b1, 1'b0, 32'h4, 32'h0);
        check("store_after_fault", rd_seen, 32'h77);
`endif
        step();
        check("fault_sticky", {31'b0, fault}, 32'h1);

        // Random traffic against the model
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(0, 49) == 0);
            ld_valid  = 1'($urandom);
            ld_addr   = AW'($urandom);
            ld_data   = $urandom;
            ld_done   = ($urandom_range(0, 4) == 0);
            mem_read  = 1'($urandom);
            mem_write = 1'($urandom);
            data_addr = rand_addr();
            data_out  = $urandom;
            step();
        end
        rst       = 1'b0;
        ld_valid  = 1'b0;
        ld_done   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
